// File: rtl/tlc_phase_sequencer.sv
// Timed highway/country traffic-light sequencer with a latched pedestrian walk phase.
// A per-phase dwell timer paces the phases; the all-red slot alternates between car and pedestrian grants.
module tlc_phase_sequencer #(
  parameter int CW        = 4,
  parameter int MIN_GREEN = 4,
  parameter int Y2RD      = 3,
  parameter int R2GD      = 2,
  parameter int MAX_CNTRY = 8,
  parameter int WALK_T    = 5
) (
  input  logic       slowclk,
  input  logic       clr_n,
  input  logic       X,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] HG   = 3'd0;
  localparam logic [2:0] HY   = 3'd1;
  localparam logic [2:0] AR1  = 3'd2;
  localparam logic [2:0] CG   = 3'd3;
  localparam logic [2:0] CY   = 3'd4;
  localparam logic [2:0] AR2  = 3'd5;
  localparam logic [2:0] WALK = 3'd6;

  localparam logic [1:0] LAMP_R = 2'd0;
  localparam logic [1:0] LAMP_Y = 2'd1;
  localparam logic [1:0] LAMP_G = 2'd2;

  // Dwell of N cycles ends on the edge where the timer reads N-1.
  localparam logic [CW-1:0] L_MIN_GREEN = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] L_Y2RD      = CW'(Y2RD - 1);
  localparam logic [CW-1:0] L_R2GD      = CW'(R2GD - 1);
  localparam logic [CW-1:0] L_MAX_CNTRY = CW'(MAX_CNTRY - 1);
  localparam logic [CW-1:0] L_WALK_T    = CW'(WALK_T - 1);
  localparam logic [CW-1:0] L_TMAX      = {CW{1'b1}};

  logic [2:0]    r_state;
  logic [CW-1:0] r_timer;
  logic          r_ped_pend;
  logic          r_last_ped;

  logic [2:0]    w_next_state;
  logic          w_grant_walk;
  logic          w_grant_cg;

  always_comb begin
    w_next_state = r_state;
    w_grant_walk = 1'b0;
    w_grant_cg   = 1'b0;
    case (r_state)
      HG:   if (r_timer >= L_MIN_GREEN && (X || r_ped_pend)) w_next_state = HY;
      HY:   if (r_timer == L_Y2RD) w_next_state = AR1;
      AR1: begin
        if (r_timer == L_R2GD) begin
          // Pedestrian wins unless the car lane is waiting and the last grant was already a walk.
          if (r_ped_pend && (!X || !r_last_ped)) begin
            w_next_state = WALK;
            w_grant_walk = 1'b1;
          end else if (X) begin
            w_next_state = CG;
            w_grant_cg   = 1'b1;
          end else begin
            w_next_state = HG;
          end
        end
      end
      CG:   if (!X || r_timer == L_MAX_CNTRY) w_next_state = CY;
      CY:   if (r_timer == L_Y2RD) w_next_state = AR2;
      AR2:  if (r_timer == L_R2GD) w_next_state = HG;
      WALK: if (r_timer == L_WALK_T) w_next_state = HG;
      default: w_next_state = HG;
    endcase
  end

  always_ff @(posedge slowclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= HG;
      r_timer    <= '0;
      r_ped_pend <= 1'b0;
      r_last_ped <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_timer <= '0;
      end else if (r_timer != L_TMAX) begin
        r_timer <= r_timer + 1'b1;
      end
      // Entering WALK consumes the request, even against a same-cycle press.
      if (w_grant_walk) begin
        r_ped_pend <= 1'b0;
      end else if (ped_req) begin
        r_ped_pend <= 1'b1;
      end
      if (w_grant_walk) begin
        r_last_ped <= 1'b1;
      end else if (w_grant_cg) begin
        r_last_ped <= 1'b0;
      end
    end
  end

  always_comb begin
    hwy   = LAMP_G;
    cntry = LAMP_R;
    walk  = 1'b0;
    case (r_state)
      HY:   hwy = LAMP_Y;
      AR1:  hwy = LAMP_R;
      CG: begin
        hwy   = LAMP_R;
        cntry = LAMP_G;
      end
      CY: begin
        hwy   = LAMP_R;
        cntry = LAMP_Y;
      end
      AR2:  hwy = LAMP_R;
      WALK: begin
        hwy  = LAMP_R;
        walk = 1'b1;
      end
      default: hwy = LAMP_G;
    endcase
  end

  assign phase = r_state;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Directed bench for tlc_phase_sequencer: per-cycle expected phase traces are queued and
// compared against the phase and lamp outputs, sampled just after each falling edge.
module tb_tlc_phase_sequencer;

  logic       slowclk = 1'b0;
  logic       clr_n   = 1'b0;
  logic       X       = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  localparam logic [2:0] P_HG   = 3'd0;
  localparam logic [2:0] P_HY   = 3'd1;
  localparam logic [2:0] P_AR1  = 3'd2;
  localparam logic [2:0] P_CG   = 3'd3;
  localparam logic [2:0] P_CY   = 3'd4;
  localparam logic [2:0] P_AR2  = 3'd5;
  localparam logic [2:0] P_WALK = 3'd6;

  // clock / reset
  always #5 slowclk = ~slowclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  tlc_phase_sequencer dut (
    .slowclk (slowclk),
    .clr_n   (clr_n),
    .X       (X),
    .ped_req (ped_req),
    .hwy     (hwy),
    .cntry   (cntry),
    .walk    (walk),
    .phase   (phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {hwy, cntry, walk} for each phase, straight from the lamp table
  function automatic logic [4:0] lamps_of(input logic [2:0] ph);
    case (ph)
      P_HY:   return {2'd1, 2'd0, 1'b0};
      P_AR1:  return {2'd0, 2'd0, 1'b0};
      P_CG:   return {2'd0, 2'd2, 1'b0};
      P_CY:   return {2'd0, 2'd1, 1'b0};
      P_AR2:  return {2'd0, 2'd0, 1'b0};
      P_WALK: return {2'd0, 2'd0, 1'b1};
      default: return {2'd2, 2'd0, 1'b0};
    endcase
  endfunction

  task automatic push(input logic [2:0] ph, input int n);
    repeat (n) exp_q.push_back(ph);
  endtask

  // driver: one cycle, called just after a falling edge
  task automatic step(input logic x, input logic p, input string tag, input int k);
    logic [2:0] e;
    X = x;
    ped_req = p;
    #1;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_c%0d: expected queue empty", tag, k);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_phase_c%0d", tag, k), {29'd0, phase}, {29'd0, e});
      check($sformatf("%s_lamps_c%0d", tag, k), {27'd0, hwy, cntry, walk}, {27'd0, lamps_of(e)});
    end
    @(negedge slowclk);
  endtask

  task automatic do_reset(input string tag);
    clr_n = 1'b0;
    X = 1'b0;
    ped_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge slowclk);
    #1;
    check({tag, "_rst_phase"}, {29'd0, phase}, 32'd0);
    check({tag, "_rst_lamps"}, {27'd0, hwy, cntry, walk}, {27'd0, 2'd2, 2'd0, 1'b0});
    @(negedge slowclk);
    clr_n = 1'b1;
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // 1 idle
    do_reset("idle");
    push(P_HG, 50);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, "idle", k);
    drain_check("idle");

    // 2 X held high: full cycle with country cap, then repeat
    do_reset("xhold");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_CG, 8);
    push(P_CY, 3); push(P_AR2, 2); push(P_HG, 4); push(P_HY, 3);
    for (int k = 0; k < 29; k++) step(1'b1, 1'b0, "xhold", k);
    drain_check("xhold");

    // 3 short X below minimum green
    do_reset("shortx");
    push(P_HG, 30);
    for (int k = 0; k < 30; k++) step(k < 2, 1'b0, "shortx", k);
    drain_check("shortx");

    // 4 single pedestrian pulse
    do_reset("ped");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_WALK, 5); push(P_HG, 20);
    for (int k = 0; k < 34; k++) step(1'b0, k == 1, "ped", k);
    drain_check("ped");

    // WALK entry clears the request even with a press on the same edge
    do_reset("pclr");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_WALK, 5); push(P_HG, 20);
    for (int k = 0; k < 34; k++) step(1'b0, (k == 1) || (k == 8), "pclr", k);
    drain_check("pclr");

    // 5 conflict: walk first, then country, then walk again (re-armed during WALK)
    do_reset("alt");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_WALK, 5);
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_CG, 8);
    push(P_CY, 3); push(P_AR2, 2); push(P_HG, 4); push(P_HY, 3);
    push(P_AR1, 2); push(P_WALK, 1);
    for (int k = 0; k < 46; k++) step(1'b1, (k == 0) || (k == 10), "alt", k);
    drain_check("alt");

    // X withdrawn during HY: AR1 returns to HG
    do_reset("wdraw");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_HG, 10);
    for (int k = 0; k < 19; k++) step(k < 4, 1'b0, "wdraw", k);
    drain_check("wdraw");

    // X drops during CG: early country exit
    do_reset("cgend");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_CG, 4);
    push(P_CY, 3); push(P_AR2, 2); push(P_HG, 8);
    for (int k = 0; k < 26; k++) step(k < 12, 1'b0, "cgend", k);
    drain_check("cgend");

    // 6 asynchronous reset in the middle of CG
    do_reset("midrst");
    push(P_HG, 4); push(P_HY, 3); push(P_AR1, 2); push(P_CG, 3);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, "midrst", k);
    #1;
    check("midrst_in_cg", {29'd0, phase}, {29'd0, P_CG});
    clr_n = 1'b0;
    #1;
    check("midrst_async_phase", {29'd0, phase}, 32'd0);
    check("midrst_async_lamps", {27'd0, hwy, cntry, walk}, {27'd0, 2'd2, 2'd0, 1'b0});
    @(negedge slowclk);
    clr_n = 1'b1;
    push(P_HG, 4); push(P_HY, 3);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, "postrst", k);
    drain_check("postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
